// File: rtl/alu_bitserial.sv
// alu_bitserial -- multi-cycle bit-serial ALU for the low-area execution option.
//
// Evaluates one bit slice per cycle, LSB first, over WIDTH cycles. The ripple
// carry lives in a register between cycles. For SLT-style codes the MSB "set"
// value is fed back into result bit 0. One extra RUN cycle after the MSB slice
// publishes the accumulated result, so done arrives WIDTH+2 cycles after the
// start cycle.
//
// Parameters:
//   WIDTH      operand/result width in bits (minimum 2)
//
// Optional feature (macro ALU_BITSERIAL_OVERFLOW_EN):
//   defined   -> adds the overflow output; SLT bit 0 becomes set ^ overflow
//                (signed compare that is correct under overflow)
//   undefined -> no overflow port; SLT bit 0 is the raw MSB of the difference
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   start      in   request, accepted only in IDLE
//   a, b       in   operands, latched on an accepted start
//   sel        in   op code: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT
//                   (011/100/101 behave SLT-like with a+b / a-b)
//   busy       out  high whenever the FSM is not IDLE
//   done       out  one-cycle pulse; result/zero/c_out valid from this cycle
//   result     out  final result, held until the next accepted start
//   zero       out  result == 0
//   c_out      out  carry out of the MSB of the arithmetic path
//   overflow   out  (macro only) signed overflow for ADD/SUB, else 0
//   state_dbg  out  current FSM state encoding (IDLE=0, RUN=1, DONE=2)
//
// Handshake: a request is the single cycle in which start=1 while busy=0;
// start is ignored while busy=1. done has no ready; it is a pulse.

module alu_bitserial #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       sel,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             c_out,
`ifdef ALU_BITSERIAL_OVERFLOW_EN
   output logic             overflow,
`endif
   output logic [1:0]       state_dbg
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state, state_n;

   logic [WIDTH-1:0] a_sh;     // operand A, shifted right one bit per slice
   logic [WIDTH-1:0] b_sh;     // operand B, shifted right one bit per slice
   logic [2:0]       sel_q;
   logic             carry;
   logic [CW-1:0]    idx;
   logic             drain;    // MSB slice done; this RUN cycle publishes
   logic [WIDTH-1:0] acc;      // partial result shift register
   logic             set_q;    // bit-0 value for SLT-like codes
   logic             cout_q;   // staged carry out of the MSB
`ifdef ALU_BITSERIAL_OVERFLOW_EN
   logic             ov_q;     // staged overflow
   logic             ov_bit;
`endif

   logic       bb;
   logic       sum;
   logic       carry_n;
   logic       res_bit;
   logic       slt_bit;
   logic       is_arith;
   logic       is_logic;
   logic       last;
   logic [WIDTH-1:0] final_res;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (start) state_n = RUN;
         RUN:     if (drain) state_n = DONE;
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   assign busy      = (state != IDLE);
   assign done      = (state == DONE);
   assign state_dbg = state;

   // ------------------------------------------------------- bit slice
   assign is_arith = (sel_q == 3'b010) || (sel_q == 3'b110);
   assign is_logic = (sel_q[2:1] == 2'b00);
   assign last     = (idx == LAST_IDX);

   always_comb begin
      bb      = sel_q[2] ? ~b_sh[0] : b_sh[0];
      sum     = a_sh[0] ^ bb ^ carry;
      carry_n = (a_sh[0] & bb) | (a_sh[0] & carry) | (bb & carry);
      case (sel_q)
         3'b000:  res_bit = a_sh[0] & b_sh[0];
         3'b001:  res_bit = a_sh[0] | b_sh[0];
         3'b010,
         3'b110:  res_bit = sum;
         default: res_bit = 1'b0;   // "less" is 0 above bit 0
      endcase
   end

`ifdef ALU_BITSERIAL_OVERFLOW_EN
   // At the MSB slice, carry holds the carry into the MSB.
   assign ov_bit  = carry ^ carry_n;
   assign slt_bit = sum ^ ov_bit;
`else
   assign slt_bit = sum;
`endif

   // Patch bit 0 with the set value for every non-logic, non-ADD/SUB code.
   always_comb begin
      final_res = acc;
      if (!is_arith && !is_logic) final_res[0] = set_q;
   end

   // -------------------------------------------------------- datapath
   always_ff @(posedge clk) begin
      if (rst) begin
         a_sh   <= '0;
         b_sh   <= '0;
         sel_q  <= '0;
         carry  <= 1'b0;
         idx    <= '0;
         drain  <= 1'b0;
         acc    <= '0;
         set_q  <= 1'b0;
         cout_q <= 1'b0;
         result <= '0;
         zero   <= 1'b0;
         c_out  <= 1'b0;
`ifdef ALU_BITSERIAL_OVERFLOW_EN
         ov_q     <= 1'b0;
         overflow <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_sh  <= a;
                  b_sh  <= b;
                  sel_q <= sel;
                  carry <= sel[2];   // +1 of the two's-complement subtract
                  idx   <= '0;
                  drain <= 1'b0;
               end
            end
            RUN: begin
               if (!drain) begin
                  a_sh  <= a_sh >> 1;
                  b_sh  <= b_sh >> 1;
                  acc   <= {res_bit, acc[WIDTH-1:1]};
                  carry <= carry_n;
                  if (last) begin
                     drain  <= 1'b1;
                     set_q  <= slt_bit;
                     cout_q <= carry_n;
`ifdef ALU_BITSERIAL_OVERFLOW_EN
                     ov_q   <= is_arith & ov_bit;
`endif
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end else begin
                  // Entry to DONE: publish the visible outputs.
                  drain  <= 1'b0;
                  result <= final_res;
                  zero   <= (final_res == '0);
                  c_out  <= cout_q;
`ifdef ALU_BITSERIAL_OVERFLOW_EN
                  overflow <= ov_q;
`endif
               end
            end
            default: ;
         endcase
      end
   end

endmodule
